mem_arbiter: RTL and testbench

- Two-requester arbiter and sequencer in front of the single shared data/instruction Memory block (64-bit words, one write port, one combinational read port).
- Requesters: instruction fetch (read-only, 32-bit zero-extended) and data load/store (all funct3 widths).
- Round-robin grant, registered request capture, fixed 2-cycle request-to-response latency.
- Sits between the core's fetch/LSU stages and Memory.

---
 rtl/mem_arbiter_pkg.sv | 28 ++
 rtl/mem_arbiter_rr_arb2.sv | 20 ++
 rtl/mem_arbiter.sv | 120 ++++++++++++
 tb/tb_mem_arbiter.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arbiter_pkg.sv
// Shared definitions for the fetch/data memory arbiter: Memory funct3 width
// selects, default bus widths, FSM state and transaction owner encodings.
package mem_arbiter_pkg;

  localparam int ADDR_LEN = 64;
  localparam int DATA_LEN = 64;

  // Memory width/sign selects (funct3 encoding)
  localparam logic [2:0] SEL_BYTE = 3'd0;
  localparam logic [2:0] SEL_HALF = 3'd1;
  localparam logic [2:0] SEL_WORD = 3'd2;
  localparam logic [2:0] SEL_DWRD = 3'd3;
  localparam logic [2:0] SEL_BYTU = 3'd4;
  localparam logic [2:0] SEL_HLFU = 3'd5;
  localparam logic [2:0] SEL_WRDU = 3'd6;

  typedef enum logic [1:0] {
    ARB_IDLE   = 2'd0,
    ARB_ACCESS = 2'd1,
    ARB_RESP   = 2'd2
  } arb_state_e;

  typedef enum logic {
    OWN_IF = 1'b0,
    OWN_D  = 1'b1
  } arb_owner_e;

endpackage

// File: rtl/mem_arbiter_rr_arb2.sv
// Two-way round-robin grant: bit 0 = fetch, bit 1 = data.
// i_last = 1 means data was served last, so fetch wins a conflict.
module rr_arb2 (
  input  logic [1:0] i_req,
  input  logic       i_last,
  output logic [1:0] o_gnt
);

  // Single requester wins outright; a conflict goes to the one not served last
  always_comb begin
    o_gnt = '0;
    case (i_req)
      2'b01:   o_gnt = 2'b01;
      2'b10:   o_gnt = 2'b10;
      2'b11:   o_gnt = i_last ? 2'b01 : 2'b10;
      default: o_gnt = '0;
    endcase
  end

endmodule

// File: rtl/mem_arbiter.sv
// Arbiter/sequencer between instruction fetch, the load/store unit and the
// shared Memory. One transaction in flight: accept, one ACCESS cycle driving
// Memory, then one RESP cycle pulsing the owner's rvalid.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int ADDR_W      = ADDR_LEN,
  parameter int DATA_W      = DATA_LEN,
  parameter int FETCH_FIRST = 1
) (
  input  logic              clk,
  input  logic              rst,
  // instruction fetch
  input  logic              if_req_i,
  input  logic [ADDR_W-1:0] if_addr_i,
  output logic              if_gnt_o,
  output logic              if_rvalid_o,
  output logic [DATA_W-1:0] if_rdata_o,
  // data load/store
  input  logic              d_req_i,
  input  logic              d_we_i,
  input  logic [2:0]        d_funct3_i,
  input  logic [ADDR_W-1:0] d_addr_i,
  input  logic [DATA_W-1:0] d_wdata_i,
  output logic              d_gnt_o,
  output logic              d_rvalid_o,
  output logic [DATA_W-1:0] d_rdata_o,
  // Memory
  output logic              mem_wen_o,
  output logic [2:0]        mem_funct3_o,
  output logic [ADDR_W-1:0] mem_waddr_o,
  output logic [ADDR_W-1:0] mem_raddr_o,
  output logic [DATA_W-1:0] mem_wdata_o,
  input  logic [DATA_W-1:0] mem_rdata_i
);

  arb_state_e  r_state;
  arb_owner_e  r_owner;
  logic [ADDR_W-1:0] r_addr;
  logic [2:0]        r_funct3;
  logic              r_we;
  logic [DATA_W-1:0] r_wdata;
  logic [DATA_W-1:0] r_resp;
  logic              r_last_d;

  logic [1:0] w_gnt;
  logic       w_can_grant;
  logic       w_if_acc;
  logic       w_d_acc;
  logic       w_access;
  logic       w_resp;

  rr_arb2 u_rr_arb2 (
    .i_req  ({d_req_i, if_req_i}),
    .i_last (r_last_d),
    .o_gnt  (w_gnt)
  );

  // Grant only when the single transaction slot is free (IDLE or RESP).
  // rst gates everything so a store in ACCESS is suppressed and no
  // response escapes while reset is held.
  always_comb begin
    w_can_grant = ~rst & ((r_state == ARB_IDLE) | (r_state == ARB_RESP));
    w_access    = ~rst & (r_state == ARB_ACCESS);
    w_resp      = ~rst & (r_state == ARB_RESP);
    if_gnt_o    = w_can_grant & w_gnt[0];
    d_gnt_o     = w_can_grant & w_gnt[1];
    w_if_acc    = if_gnt_o & if_req_i;
    w_d_acc     = d_gnt_o & d_req_i;
  end

  // Response and Memory-side outputs, decoded from the registered state
  always_comb begin
    if_rvalid_o  = w_resp & (r_owner == OWN_IF);
    d_rvalid_o   = w_resp & (r_owner == OWN_D);
    if_rdata_o   = if_rvalid_o ? r_resp : '0;
    d_rdata_o    = d_rvalid_o ? r_resp : '0;
    mem_wen_o    = w_access ? ~r_we : 1'b1;
    mem_funct3_o = w_access ? r_funct3 : '0;
    mem_waddr_o  = w_access ? r_addr : '0;
    mem_raddr_o  = w_access ? r_addr : '0;
    mem_wdata_o  = w_access ? r_wdata : '0;
  end

  // Sequencer FSM: capture on accept, access Memory, present response
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= ARB_IDLE;
      r_owner  <= OWN_IF;
      r_addr   <= '0;
      r_funct3 <= '0;
      r_we     <= 1'b0;
      r_wdata  <= '0;
      r_resp   <= '0;
      r_last_d <= (FETCH_FIRST != 0);
    end else begin
      case (r_state)
        ARB_IDLE, ARB_RESP: begin
          if (w_if_acc | w_d_acc) begin
            r_owner  <= w_d_acc ? OWN_D : OWN_IF;
            r_addr   <= w_d_acc ? d_addr_i : if_addr_i;
            r_funct3 <= w_d_acc ? d_funct3_i : SEL_WRDU;
            r_we     <= w_d_acc & d_we_i;
            r_wdata  <= w_d_acc ? d_wdata_i : '0;
            r_last_d <= w_d_acc;
            r_state  <= ARB_ACCESS;
          end else begin
            r_state  <= ARB_IDLE;
          end
        end
        ARB_ACCESS: begin
          r_resp  <= r_we ? '0 : mem_rdata_i;
          r_state <= ARB_RESP;
        end
        default: r_state <= ARB_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a small behavioural Memory model.
module tb_mem_arbiter;
  import mem_arbiter_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        if_req_i;
  logic [63:0] if_addr_i;
  logic        if_gnt_o;
  logic        if_rvalid_o;
  logic [63:0] if_rdata_o;
  logic        d_req_i;
  logic        d_we_i;
  logic [2:0]  d_funct3_i;
  logic [63:0] d_addr_i;
  logic [63:0] d_wdata_i;
  logic        d_gnt_o;
  logic        d_rvalid_o;
  logic [63:0] d_rdata_o;
  logic        mem_wen_o;
  logic [2:0]  mem_funct3_o;
  logic [63:0] mem_waddr_o;
  logic [63:0] mem_raddr_o;
  logic [63:0] mem_wdata_o;
  logic [63:0] mem_rdata_i;

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  logic [63:0] mem [0:31];

  always #5 clk = ~clk;

  mem_arbiter #(.ADDR_W(64), .DATA_W(64), .FETCH_FIRST(1)) dut (
    .clk(clk), .rst(rst),
    .if_req_i(if_req_i), .if_addr_i(if_addr_i), .if_gnt_o(if_gnt_o),
    .if_rvalid_o(if_rvalid_o), .if_rdata_o(if_rdata_o),
    .d_req_i(d_req_i), .d_we_i(d_we_i), .d_funct3_i(d_funct3_i),
    .d_addr_i(d_addr_i), .d_wdata_i(d_wdata_i), .d_gnt_o(d_gnt_o),
    .d_rvalid_o(d_rvalid_o), .d_rdata_o(d_rdata_o),
    .mem_wen_o(mem_wen_o), .mem_funct3_o(mem_funct3_o),
    .mem_waddr_o(mem_waddr_o), .mem_raddr_o(mem_raddr_o),
    .mem_wdata_o(mem_wdata_o), .mem_rdata_i(mem_rdata_i)
  );

  function automatic logic [63:0] mem_read(input logic [63:0] w, input logic [2:0] f3);
    case (f3)
      SEL_BYTE: mem_read = {{56{w[7]}}, w[7:0]};
      SEL_HALF: mem_read = {{48{w[15]}}, w[15:0]};
      SEL_WORD: mem_read = {{32{w[31]}}, w[31:0]};
      SEL_DWRD: mem_read = w;
      SEL_BYTU: mem_read = {56'd0, w[7:0]};
      SEL_HLFU: mem_read = {48'd0, w[15:0]};
      SEL_WRDU: mem_read = {32'd0, w[31:0]};
      default:  mem_read = '0;
    endcase
  endfunction

  function automatic logic [63:0] mem_merge(input logic [63:0] old, input logic [63:0] d,
                                            input logic [2:0] f3);
    case (f3)
      SEL_BYTE, SEL_BYTU: mem_merge = {old[63:8], d[7:0]};
      SEL_HALF, SEL_HLFU: mem_merge = {old[63:16], d[15:0]};
      SEL_WORD, SEL_WRDU: mem_merge = {old[63:32], d[31:0]};
      default:            mem_merge = d;
    endcase
  endfunction

  assign mem_rdata_i = mem_read(mem[mem_raddr_o[4:0]], mem_funct3_o);

  always @(posedge clk)
    if (!mem_wen_o)
      mem[mem_waddr_o[4:0]] <= mem_merge(mem[mem_waddr_o[4:0]], mem_wdata_o, mem_funct3_o);

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    for (int i = 0; i < 32; i++) mem[i] = '0;
    mem[16] = 64'hDEADBEEF_12345678;
    mem[7]  = 64'h1;
    rst = 1'b1;
    if_req_i = 1'b0; if_addr_i = '0;
    d_req_i = 1'b0; d_we_i = 1'b0; d_funct3_i = '0; d_addr_i = '0; d_wdata_i = '0;

    // reset state
    tick(); tick();
    @(negedge clk);
    check("rst_wen", mem_wen_o, 1'b1);
    check("rst_if_rvalid", if_rvalid_o, 1'b0);
    check("rst_d_rvalid", d_rvalid_o, 1'b0);
    check("rst_raddr", mem_raddr_o, 64'h0);
    tick();
    rst = 1'b0;

    // fetch only
    if_req_i = 1'b1; if_addr_i = 64'h10;
    @(negedge clk);
    check("f_if_gnt", if_gnt_o, 1'b1);
    check("f_d_gnt", d_gnt_o, 1'b0);
    tick(); if_req_i = 1'b0;
    @(negedge clk);
    check("f_raddr", mem_raddr_o, 64'h10);
    check("f_funct3", mem_funct3_o, SEL_WRDU);
    check("f_wen", mem_wen_o, 1'b1);
    check("f_rvalid_early", if_rvalid_o, 1'b0);
    tick();
    @(negedge clk);
    check("f_rvalid", if_rvalid_o, 1'b1);
    check("f_rdata", if_rdata_o, 64'h0000_0000_1234_5678);
    check("f_d_rvalid", d_rvalid_o, 1'b0);
    tick();
    @(negedge clk);
    check("f_rvalid_end", if_rvalid_o, 1'b0);
    check("f_rdata_end", if_rdata_o, 64'h0);

    // store then back-to-back load to the same address
    tick();
    d_req_i = 1'b1; d_we_i = 1'b1; d_funct3_i = SEL_DWRD; d_addr_i = 64'd5;
    d_wdata_i = {8{8'hA5}};
    @(negedge clk);
    check("st_gnt", d_gnt_o, 1'b1);
    check("st_wen_idle", mem_wen_o, 1'b1);
    tick();
    d_we_i = 1'b0; d_funct3_i = SEL_BYTU; d_wdata_i = '0;
    @(negedge clk);
    check("st_gnt_access", d_gnt_o, 1'b0);
    check("st_wen", mem_wen_o, 1'b0);
    check("st_waddr", mem_waddr_o, 64'd5);
    check("st_wdata", mem_wdata_o, {8{8'hA5}});
    tick();
    @(negedge clk);
    check("st_ack", d_rvalid_o, 1'b1);
    check("st_ack_data", d_rdata_o, 64'h0);
    check("ld_gnt_in_resp", d_gnt_o, 1'b1);
    check("st_wen_resp", mem_wen_o, 1'b1);
    check("st_mem", mem[5], {8{8'hA5}});
    tick(); d_req_i = 1'b0;
    @(negedge clk);
    check("ld_raddr_b2b", mem_raddr_o, 64'd5);
    check("ld_funct3", mem_funct3_o, SEL_BYTU);
    check("ld_wen", mem_wen_o, 1'b1);
    tick();
    @(negedge clk);
    check("ld_rvalid", d_rvalid_o, 1'b1);
    check("ld_rdata", d_rdata_o, 64'hA5);
    tick();
    @(negedge clk);
    check("ld_rvalid_end", d_rvalid_o, 1'b0);

    // simultaneous requests: alternate F, D, ... starting with fetch
    tick();
    if_req_i = 1'b1; if_addr_i = 64'h10;
    d_req_i = 1'b1; d_we_i = 1'b0; d_funct3_i = SEL_DWRD; d_addr_i = 64'd5;
    for (int c = 0; c < 17; c++) begin
      @(negedge clk);
      if (c % 2 == 0 && c < 16) begin
        check("rr_if_gnt", if_gnt_o, ((c / 2) % 2 == 0));
        check("rr_d_gnt", d_gnt_o, ((c / 2) % 2 == 1));
      end else begin
        check("rr_no_gnt", {if_gnt_o, d_gnt_o}, 2'b00);
      end
      if (c % 2 == 0 && c >= 2) begin
        if (((c / 2) - 1) % 2 == 0) begin
          check("rr_if_rvalid", {if_rvalid_o, d_rvalid_o}, 2'b10);
          check("rr_if_rdata", if_rdata_o, 64'h0000_0000_1234_5678);
        end else begin
          check("rr_d_rvalid", {if_rvalid_o, d_rvalid_o}, 2'b01);
          check("rr_d_rdata", d_rdata_o, {8{8'hA5}});
        end
      end else begin
        check("rr_no_rvalid", {if_rvalid_o, d_rvalid_o}, 2'b00);
      end
      tick();
      if (c == 14) begin
        if_req_i = 1'b0;
        d_req_i  = 1'b0;
      end
    end

    // reset during the ACCESS of a store to addr 7
    d_req_i = 1'b1; d_we_i = 1'b1; d_funct3_i = SEL_DWRD; d_addr_i = 64'd7;
    d_wdata_i = '1;
    @(negedge clk);
    check("rs_gnt", d_gnt_o, 1'b1);
    tick();
    d_req_i = 1'b0; rst = 1'b1;
    @(negedge clk);
    check("rs_wen_access", mem_wen_o, 1'b1);
    check("rs_d_rvalid", d_rvalid_o, 1'b0);
    tick();
    rst = 1'b0;
    if_req_i = 1'b1; if_addr_i = 64'h10;
    d_req_i = 1'b1; d_we_i = 1'b0; d_funct3_i = SEL_DWRD; d_addr_i = 64'd7;
    @(negedge clk);
    check("rs_mem7", mem[7], 64'h1);
    check("rs_no_rvalid", {if_rvalid_o, d_rvalid_o}, 2'b00);
    check("rs_wen_idle", mem_wen_o, 1'b1);
    check("rs_fetch_first", {if_gnt_o, d_gnt_o}, 2'b10);
    tick();
    if_req_i = 1'b0; d_req_i = 1'b0;
    @(negedge clk);
    check("rs_fetch_access", mem_raddr_o, 64'h10);
    tick();
    @(negedge clk);
    check("rs_fetch_rdata", if_rdata_o, 64'h0000_0000_1234_5678);
    tick();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
